// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT bit-reversal reorder buffer.
package fft_pkg;

  localparam int unsigned I_EXP = 8;
  localparam int unsigned I_MNT = 23;
  localparam int unsigned FP_W  = I_EXP + I_MNT + 1;

  typedef logic [FP_W-1:0] fp_t;

  typedef struct packed {
    fp_t r;
    fp_t i;
  } complex_fp_t;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  // Reverses the low log2n bits of v; bits above log2n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned log2n);
    logic [31:0] r;
    r = '0;
    for (int unsigned j = 0; j < 32; j++) begin
      if (j < log2n) r = {r[30:0], v[j[4:0]]};
    end
    return r;
  endfunction

  // Divides one float component by 2**sh; small exponents flush to signed zero, Inf/NaN pass.
  function automatic fp_t fp_scale(input fp_t x, input int unsigned sh);
    logic [I_EXP-1:0] e;
    e = x[FP_W-2 -: I_EXP];
    if (e == '1) return x;
    if ({24'd0, e} <= sh) return {x[FP_W-1], {(FP_W-1){1'b0}}};
    return {x[FP_W-1], e - I_EXP'(sh), x[I_MNT-1:0]};
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Butterfly-side pair input and consumer-side sample output of the reorder buffer.
// FFT_REORDER_IFFT_SCALE_EN adds the per-frame ifft_scale input.
interface fft_bitrev_reorder_if import fft_pkg::*; #(
  parameter int unsigned LOG2N = 6
) ();

  logic             in_valid;
  complex_fp_t      in_X;
  complex_fp_t      in_Y;
  logic             in_ready;
  complex_fp_t      out_data;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
`ifdef FFT_REORDER_IFFT_SCALE_EN
  logic             ifft_scale;

  modport slave (
    input  in_valid, in_X, in_Y, out_ready, ifft_scale,
    output in_ready, out_data, out_index, out_last, out_valid, overflow
  );
  modport master (
    output in_valid, in_X, in_Y, out_ready, ifft_scale,
    input  in_ready, out_data, out_index, out_last, out_valid, overflow
  );
`else
  modport slave (
    input  in_valid, in_X, in_Y, out_ready,
    output in_ready, out_data, out_index, out_last, out_valid, overflow
  );
  modport master (
    output in_valid, in_X, in_Y, out_ready,
    input  in_ready, out_data, out_index, out_last, out_valid, overflow
  );
`endif

endinterface

// File: rtl/reorder_bank.sv
// One ping-pong bank: lower/upper half-RAMs with a shared write offset and one registered read port.
module reorder_bank import fft_pkg::*; #(
  parameter  int unsigned N_POINTS = 64,
  localparam int unsigned LOG2N    = $clog2(N_POINTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [LOG2N-2:0] wr_addr,
  input  complex_fp_t      wr_lo,
  input  complex_fp_t      wr_hi,
  input  logic             rd_en,
  input  logic [LOG2N-1:0] rd_addr,
  output complex_fp_t      rd_data
);

  complex_fp_t lo_ram [N_POINTS/2];
  complex_fp_t hi_ram [N_POINTS/2];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      lo_ram[wr_addr] <= wr_lo;
      hi_ram[wr_addr] <= wr_hi;
    end
  end

  // The read register doubles as the output data register, so it only moves on rd_en.
  always_ff @(posedge clk) begin
    if (!reset)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= rd_addr[LOG2N-1] ? hi_ram[rd_addr[LOG2N-2:0]] : lo_ram[rd_addr[LOG2N-2:0]];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed pair capture into two banks, natural-order single-sample output stream.
// Optional FFT_REORDER_IFFT_SCALE_EN: per-frame 1/N exponent scaling on read.
module fft_bitrev_reorder import fft_pkg::*; #(
  parameter  int unsigned N_POINTS = 64,
  localparam int unsigned LOG2N    = $clog2(N_POINTS)
) (
  input logic                 clk,
  input logic                 reset,
  fft_bitrev_reorder_if.slave bus
);

  localparam int unsigned HALF = N_POINTS / 2;

  bank_state_t      st [2];
  bank_state_t      st_nx [2];
  logic             wsel, rsel, osel, iss_bank, iss_active;
  logic [LOG2N-2:0] wr_cnt;
  logic [LOG2N-2:0] wr_addr;
  logic [LOG2N-1:0] rd_ptr, out_index;
  logic             out_valid, out_last, overflow;
  logic             in_ready, accept, last_pair, adv, issue, done_hs, rd_last;
  logic [1:0]       start;
  complex_fp_t      bank_q [2];
  complex_fp_t      raw;

  assign in_ready  = (st[wsel] == EMPTY) || (st[wsel] == FILLING);
  assign accept    = bus.in_valid && in_ready;
  assign last_pair = (wr_cnt == (LOG2N-1)'(HALF - 1));
  assign wr_addr   = (LOG2N-1)'(bitrev(32'({wr_cnt, 1'b0}), LOG2N));
  assign adv       = !out_valid || bus.out_ready;
  assign issue     = iss_active && adv;
  assign rd_last   = (rd_ptr == LOG2N'(N_POINTS - 1));
  assign done_hs   = out_valid && bus.out_ready && out_last;

  // A FULL bank that is not rsel starts draining as soon as the rsel bank has issued its
  // final read, so the next frame's first read lands on the same edge as the last handshake.
  always_comb begin
    st_nx = st;
    start = '0;
    for (int unsigned b = 0; b < 2; b++) begin
      start[b] = (st[b] == FULL) &&
                 ((1'(b) == rsel) ||
                  ((st[rsel] == DRAINING) && (!iss_active || (adv && rd_last))));
      case (st[b])
        EMPTY:    if (accept && (wsel == 1'(b))) st_nx[b] = FILLING;
        FILLING:  if (accept && (wsel == 1'(b)) && last_pair) st_nx[b] = FULL;
        FULL:     if (start[b]) st_nx[b] = DRAINING;
        DRAINING: if (done_hs && (rsel == 1'(b))) st_nx[b] = EMPTY;
        default:  st_nx[b] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st[0]      <= EMPTY;
      st[1]      <= EMPTY;
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      osel       <= 1'b0;
      iss_bank   <= 1'b0;
      iss_active <= 1'b0;
      wr_cnt     <= '0;
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_last   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      st <= st_nx;
      if (bus.in_valid && !in_ready) overflow <= 1'b1;
      if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (last_pair) wsel <= !wsel;
      end
      if (done_hs) rsel <= !rsel;
      if (adv) begin
        out_valid <= iss_active;
        if (iss_active) begin
          out_index <= rd_ptr;
          out_last  <= rd_last;
          osel      <= iss_bank;
          rd_ptr    <= rd_ptr + 1'b1;
          if (rd_last) iss_active <= 1'b0;
        end
      end
      if (|start) begin
        iss_active <= 1'b1;
        iss_bank   <= start[1];
        rd_ptr     <= '0;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    reorder_bank #(.N_POINTS(N_POINTS)) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept && (wsel == 1'(g))),
      .wr_addr (wr_addr),
      .wr_lo   (bus.in_X),
      .wr_hi   (bus.in_Y),
      .rd_en   (issue && (iss_bank == 1'(g))),
      .rd_addr (rd_ptr),
      .rd_data (bank_q[g])
    );
  end

  assign raw = bank_q[osel];

`ifdef FFT_REORDER_IFFT_SCALE_EN
  logic [1:0] scale_frame;
  logic       oscale;

  always_ff @(posedge clk) begin
    if (!reset) begin
      scale_frame <= '0;
      oscale      <= 1'b0;
    end else begin
      if (accept && (st[wsel] == EMPTY)) scale_frame[wsel] <= bus.ifft_scale;
      if (issue) oscale <= scale_frame[iss_bank];
    end
  end

  assign bus.out_data = oscale ? {fp_scale(raw.r, LOG2N), fp_scale(raw.i, LOG2N)} : raw;
`else
  assign bus.out_data = raw;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_index = out_index;
  assign bus.out_last  = out_last;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder at N=8 against a frame-level reorder model.
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned LG = 3;

  typedef struct {
    int unsigned idx;
    complex_fp_t data;
  } sample_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.LOG2N(LG)) bus ();
  fft_bitrev_reorder #(.N_POINTS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  sample_t     exp_q[$];
  complex_fp_t frame_buf [N];
  int unsigned pairs_in = 0;
  int unsigned occ = 0;
  logic        ovf_m = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        stalled = 1'b0;
  logic [LG-1:0] held_idx;
  complex_fp_t held_data;
  bit          gap_watch = 0;
  bit          started = 0;
  int unsigned delivered = 0;
  int unsigned gaps = 0;

  function automatic int unsigned rev(input int unsigned v);
    int unsigned r = 0;
    for (int i = 0; i < LG; i++)
      if ((v >> i) & 1) r = r + (1 << (LG - 1 - i));
    return r;
  endfunction

  function automatic complex_fp_t rnd_c();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input complex_fp_t x, input complex_fp_t y);
    bus.in_valid = v;
    bus.in_X     = x;
    bus.in_Y     = y;
  endtask

  // One clock: check outputs at negedge, then advance the model on the posedge.
  task automatic cycle();
    logic    ready_m, acc;
    sample_t s;
    complex_fp_t nat [N];
    @(negedge clk);
    ready_m = (pairs_in != 0) || (occ < 2);
    chk("in_ready", 64'(bus.in_ready), 64'(ready_m));
    chk("overflow", 64'(bus.overflow), 64'(ovf_m));
    if (stalled) begin
      chk("hold_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_index", 64'(bus.out_index), 64'(held_idx));
      chk("hold_data", bus.out_data, held_data);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(bus.out_valid), 64'(0));
      end else begin
        s = exp_q.pop_front();
        chk("out_index", 64'(bus.out_index), 64'(s.idx));
        chk("out_data", bus.out_data, s.data);
        chk("out_last", 64'(bus.out_last), 64'(s.idx == N - 1));
        if (s.idx == N - 1) occ--;
        delivered++;
      end
    end
    if (gap_watch) begin
      if (bus.out_valid) started = 1;
      else if (started && delivered < 3 * N) gaps++;
    end
    stalled   = bus.out_valid && !bus.out_ready;
    held_idx  = bus.out_index;
    held_data = bus.out_data;
    acc = bus.in_valid && ready_m;
    if (bus.in_valid && !ready_m) ovf_m = 1'b1;
    @(posedge clk);
    if (acc) begin
      if (pairs_in == 0) occ++;
      frame_buf[2 * pairs_in]     = bus.in_X;
      frame_buf[2 * pairs_in + 1] = bus.in_Y;
      pairs_in++;
      if (pairs_in == N / 2) begin
        for (int unsigned p = 0; p < N; p++) nat[rev(p)] = frame_buf[p];
        for (int unsigned b = 0; b < N; b++) exp_q.push_back('{idx: b, data: nat[b]});
        pairs_in = 0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(1'b0, '0, '0);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_index", 64'(bus.out_index), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_out_data", bus.out_data, 64'(0));
    chk("rst_overflow", 64'(bus.overflow), 64'(0));
    reset = 1'b1;
    exp_q.delete();
    pairs_in = 0;
    occ      = 0;
    ovf_m    = 1'b0;
    stalled  = 1'b0;
  endtask

  task automatic send_frame(input int unsigned idle_after);
    for (int unsigned k = 0; k < N / 2; k++) begin
      drive(1'b1, rnd_c(), rnd_c());
      cycle();
    end
    drive(1'b0, '0, '0);
    repeat (idle_after) cycle();
  endtask

  task automatic drain(input bit rnd_ready);
    int unsigned budget = 400;
    drive(1'b0, '0, '0);
    while (exp_q.size() != 0 && budget != 0) begin
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      budget--;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    bus.out_ready = 1'b1;
    repeat (3) cycle();
  endtask

  initial begin
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
`ifdef FFT_REORDER_IFFT_SCALE_EN
    bus.ifft_scale = 1'b0;
`endif
    apply_reset();

    // 1: one frame whose data equals its natural bin; check first-output latency
    for (int unsigned k = 0; k < N / 2; k++) begin
      drive(1'b1, {32'(rev(2 * k)), 32'd0}, {32'(rev(2 * k + 1)), 32'd0});
      cycle();
    end
    drive(1'b0, '0, '0);
    chk("lat_edge0", 64'(bus.out_valid), 64'(0));
    cycle();
    chk("lat_edge1", 64'(bus.out_valid), 64'(0));
    cycle();
    chk("lat_edge2", 64'(bus.out_valid), 64'(1));
    chk("first_index", 64'(bus.out_index), 64'(0));
    drain(1'b0);

    // 2: three frames at one frame per N cycles, output always ready
    gap_watch = 1; started = 0; delivered = 0; gaps = 0;
    for (int f = 0; f < 3; f++) send_frame(N / 2);
    drain(1'b0);
    chk("no_gap", 64'(gaps), 64'(0));
    chk("delivered", 64'(delivered), 64'(3 * N));
    gap_watch = 0;

    // 3: consumer stalled while three frames arrive at full rate
    bus.out_ready = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(0);
    chk("ovf_set", 64'(bus.overflow), 64'(1));
    chk("in_ready_low", 64'(bus.in_ready), 64'(0));
    drain(1'b0);

    // 4: random input gaps and random output backpressure
    apply_reset();
    for (int unsigned c = 0; c < 120; c++) begin
      drive(1'($urandom_range(0, 1)), rnd_c(), rnd_c());
      bus.out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    drain(1'b1);

    // 5: reset mid-fill, then mid-drain, then a clean frame
    apply_reset();
    drive(1'b1, rnd_c(), rnd_c()); cycle();
    drive(1'b1, rnd_c(), rnd_c()); cycle();
    apply_reset();
    send_frame(5);
    apply_reset();
    send_frame(0);
    drain(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
